// File: rtl/radar_scan_ctrl_if.sv
// Control, ranger and buffer-read signals of the radar sweep sequencer.
// The master side drives stimulus and read addresses; the slave side is the sequencer.
interface radar_scan_ctrl_if;
   logic        start;
   logic        continuous;
   logic        done_in;
   logic [15:0] distance_in;
   logic [1:0]  grados;
   logic        ultra;
   logic        busy;
   logic        sweep_done;
   logic [1:0]  rd_addr;
   logic [15:0] rd_data;
   logic [15:0] min_dist;
   logic [1:0]  min_pos;
   logic        obstacle;
   logic [2:0]  timeout_flags;

   modport master (
      output start, continuous, done_in, distance_in, rd_addr,
      input  grados, ultra, busy, sweep_done, rd_data, min_dist, min_pos,
             obstacle, timeout_flags
   );

   modport slave (
      input  start, continuous, done_in, distance_in, rd_addr,
      output grados, ultra, busy, sweep_done, rd_data, min_dist, min_pos,
             obstacle, timeout_flags
   );
endinterface

// File: rtl/radar_scan_ctrl.sv
// Three-position servo sweep sequencer: settle, measure with timeout, buffer the
// results and publish the nearest-obstacle summary at the end of each sweep.
module radar_scan_ctrl #(
   parameter int          SETTLE_CYCLES  = 25_000_000,
   parameter int          TIMEOUT_CYCLES = 5_000_000,
   parameter logic [15:0] OBST_THRESH    = 16'd20
) (
   input logic              clk,
   input logic              rst_n,
   radar_scan_ctrl_if.slave bus
);
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, MOVE, MEASURE, NEXT, FINISH} state_t;

   state_t        state_reg, state_next;
   logic [1:0]    pos_reg, pos_next;
   logic [1:0]    grados_reg, grados_next;
   logic [SW-1:0] settle_reg, settle_next;
   logic [TW-1:0] tmo_reg, tmo_next;
   logic          done_prev_reg;
   logic [2:0]    tflags_reg, tflags_next;
   logic [15:0]   min_dist_reg, min_dist_next;
   logic [1:0]    min_pos_reg, min_pos_next;
   logic          obstacle_reg, obstacle_next;
   logic          wr_en;
   logic [15:0]   wr_data;
   logic [15:0]   buf_reg [3];
   logic [15:0]   cand_dist;
   logic [1:0]    cand_pos;
   logic          done_edge;

   assign done_edge = bus.done_in & ~done_prev_reg;

   // Strict-less scan in position order so ties keep the lower position.
   always_comb begin
      cand_dist = buf_reg[0];
      cand_pos  = 2'd0;
      if (buf_reg[1] < cand_dist) begin
         cand_dist = buf_reg[1];
         cand_pos  = 2'd1;
      end
      if (buf_reg[2] < cand_dist) begin
         cand_dist = buf_reg[2];
         cand_pos  = 2'd2;
      end
   end

   always_comb begin
      state_next    = state_reg;
      pos_next      = pos_reg;
      grados_next   = grados_reg;
      settle_next   = settle_reg;
      tmo_next      = tmo_reg;
      tflags_next   = tflags_reg;
      min_dist_next = min_dist_reg;
      min_pos_next  = min_pos_reg;
      obstacle_next = obstacle_reg;
      wr_en         = 1'b0;
      wr_data       = bus.distance_in;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               state_next  = MOVE;
               pos_next    = 2'd0;
               grados_next = 2'd0;
               settle_next = '0;
               tflags_next = 3'b000;
            end
         end
         MOVE: begin
            if (settle_reg == SETTLE_LAST) begin
               state_next = MEASURE;
               tmo_next   = '0;
            end else begin
               settle_next = settle_reg + 1'b1;
            end
         end
         MEASURE: begin
            // A done edge takes priority over a timeout landing in the same cycle.
            if (done_edge) begin
               wr_en      = 1'b1;
               state_next = NEXT;
            end else if (tmo_reg == TIMEOUT_LAST) begin
               wr_en       = 1'b1;
               wr_data     = 16'hFFFF;
               tflags_next = tflags_reg | (3'b001 << pos_reg);
               state_next  = NEXT;
            end else begin
               tmo_next = tmo_reg + 1'b1;
            end
         end
         NEXT: begin
            if (pos_reg == 2'd2) begin
               state_next = FINISH;
            end else begin
               state_next  = MOVE;
               pos_next    = pos_reg + 2'd1;
               grados_next = pos_reg + 2'd1;
               settle_next = '0;
            end
         end
         FINISH: begin
            min_dist_next = cand_dist;
            min_pos_next  = cand_pos;
            obstacle_next = (cand_dist < OBST_THRESH);
            if (bus.continuous) begin
               state_next  = MOVE;
               pos_next    = 2'd0;
               grados_next = 2'd0;
               settle_next = '0;
               tflags_next = 3'b000;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         pos_reg       <= 2'd0;
         grados_reg    <= 2'd0;
         settle_reg    <= '0;
         tmo_reg       <= '0;
         done_prev_reg <= 1'b0;
         tflags_reg    <= 3'b000;
         min_dist_reg  <= 16'hFFFF;
         min_pos_reg   <= 2'd0;
         obstacle_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pos_reg       <= pos_next;
         grados_reg    <= grados_next;
         settle_reg    <= settle_next;
         tmo_reg       <= tmo_next;
         done_prev_reg <= bus.done_in;
         tflags_reg    <= tflags_next;
         min_dist_reg  <= min_dist_next;
         min_pos_reg   <= min_pos_next;
         obstacle_reg  <= obstacle_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_buf
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               buf_reg[gi] <= 16'hFFFF;
            end else if (wr_en && (pos_reg == 2'(gi))) begin
               buf_reg[gi] <= wr_data;
            end
         end
      end
   endgenerate

   always_comb begin
      case (bus.rd_addr)
         2'd0:    bus.rd_data = buf_reg[0];
         2'd1:    bus.rd_data = buf_reg[1];
         2'd2:    bus.rd_data = buf_reg[2];
         default: bus.rd_data = min_dist_reg;
      endcase
   end

   assign bus.grados        = grados_reg;
   assign bus.ultra         = (state_reg == MEASURE);
   assign bus.busy          = (state_reg != IDLE);
   assign bus.sweep_done    = (state_reg == FINISH);
   assign bus.min_dist      = min_dist_reg;
   assign bus.min_pos       = min_pos_reg;
   assign bus.obstacle      = obstacle_reg;
   assign bus.timeout_flags = tflags_reg;
endmodule
